// File: rtl/wash_program_sequencer_pkg.sv
// Shared types for the wash program sequencer: state encoding, cycle modes,
// per-mode phase durations and per-phase energy rates.
package wash_program_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOCK  = 4'd1,
        ST_FILL  = 4'd2,
        ST_HEAT  = 4'd3,
        ST_WASH  = 4'd4,
        ST_RINSE = 4'd5,
        ST_SPIN  = 4'd6,
        ST_DONE  = 4'd7,
        ST_FAULT = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'b00,
        MODE_QUICK    = 2'b01,
        MODE_HEAVY    = 2'b10,
        MODE_DELICATE = 2'b11
    } mode_e;

    typedef struct packed {
        logic [7:0] wash;
        logic [7:0] rinse;
        logic [7:0] spin;
    } durations_t;

    localparam logic [2:0] RATE_FILL  = 3'd1;
    localparam logic [2:0] RATE_HEAT  = 3'd4;
    localparam logic [2:0] RATE_WASH  = 3'd2;
    localparam logic [2:0] RATE_RINSE = 3'd1;
    localparam logic [2:0] RATE_SPIN  = 3'd3;

    function automatic durations_t mode_durations(input mode_e m);
        durations_t d;
        case (m)
            MODE_QUICK:    d = '{wash: 8'd20, rinse: 8'd10, spin: 8'd15};
            MODE_HEAVY:    d = '{wash: 8'd60, rinse: 8'd30, spin: 8'd40};
            MODE_DELICATE: d = '{wash: 8'd30, rinse: 8'd20, spin: 8'd10};
            default:       d = '{wash: 8'd40, rinse: 8'd20, spin: 8'd30};
        endcase
        return d;
    endfunction

    function automatic logic [2:0] energy_rate(input state_e s);
        case (s)
            ST_FILL:  return RATE_FILL;
            ST_HEAT:  return RATE_HEAT;
            ST_WASH:  return RATE_WASH;
            ST_RINSE: return RATE_RINSE;
            ST_SPIN:  return RATE_SPIN;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/wash_program_sequencer_phase_timer.sv
// Loadable down-counter: load wins over decrement, holds when dec is low,
// and flags expiry once the count reaches zero.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/wash_program_sequencer.sv
// Wash program sequencer: lock, fill, heat, wash, N rinses, spin, with
// pause/door freeze, fill/heat timeout and a saturating energy total.
module wash_program_sequencer
    import wash_program_sequencer_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int ENERGY_W  = 12,
    parameter int MAX_RINSE = 3,
    parameter int TIMEOUT   = 200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                pause,
    input  logic                enable_lock,
    input  logic                water_ready,
    input  logic                temp_ready,
    input  logic                sense_ok,
    input  logic [1:0]          cycle_mode,
    input  logic [1:0]          rinse_count,
    output logic                fill_valve,
    output logic                heater_on,
    output logic                wash_enable,
    output logic                rinse_enable,
    output logic                spin_enable,
    output logic                busy,
    output logic                complete,
    output logic                fault,
    output logic [3:0]          phase,
    output logic [ENERGY_W-1:0] energy_consumed
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [1:0]          rinse_q, rinse_d;
    logic [ENERGY_W-1:0] energy_q, energy_d;
    logic [ENERGY_W:0]   energy_sum;

    logic             tmr_load, tmr_dec, tmr_expired;
    logic [CNT_W-1:0] tmr_val;
    logic             active, hold;
    durations_t       dur;

    phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .expired  (tmr_expired)
    );

    assign active = (state_q inside {ST_FILL, ST_HEAT, ST_WASH, ST_RINSE, ST_SPIN});
    assign hold   = active && (pause || !enable_lock);
    assign dur    = mode_durations(mode_q);

    assign energy_sum = {1'b0, energy_q} + (ENERGY_W+1)'(energy_rate(state_q));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rinse_d  = rinse_q;
        energy_d = energy_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        if (active && !hold)
            energy_d = energy_sum[ENERGY_W] ? {ENERGY_W{1'b1}} : energy_sum[ENERGY_W-1:0];

        case (state_q)
            ST_IDLE: if (start) begin
                state_d  = ST_LOCK;
                mode_d   = mode_e'(cycle_mode);
                energy_d = '0;
                if (rinse_count == 2'd0)
                    rinse_d = 2'd1;
                else if (int'(rinse_count) > MAX_RINSE)
                    rinse_d = 2'(MAX_RINSE);
                else
                    rinse_d = rinse_count;
            end
            ST_LOCK: if (enable_lock) begin
                state_d  = ST_FILL;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(TIMEOUT - 1);
            end
            ST_FILL: if (!hold) begin
                if (water_ready) begin
                    state_d  = ST_HEAT;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(TIMEOUT - 1);
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HEAT: if (!hold) begin
                if (temp_ready) begin
                    if (sense_ok) begin
                        state_d  = ST_WASH;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(int'(dur.wash) - 1);
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WASH: if (!hold) begin
                if (tmr_expired) begin
                    state_d  = ST_RINSE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(int'(dur.rinse) - 1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            // rinse_q counts the passes still owed, including the current one
            ST_RINSE: if (!hold) begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    if (rinse_q <= 2'd1) begin
                        state_d = ST_SPIN;
                        rinse_d = 2'd0;
                        tmr_val = CNT_W'(int'(dur.spin) - 1);
                    end else begin
                        rinse_d = rinse_q - 2'd1;
                        tmr_val = CNT_W'(int'(dur.rinse) - 1);
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SPIN: if (!hold) begin
                if (tmr_expired) state_d = ST_DONE;
                else             tmr_dec = 1'b1;
            end
            ST_DONE: if (!start) state_d = ST_IDLE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_NORMAL;
            rinse_q  <= '0;
            energy_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rinse_q  <= rinse_d;
            energy_q <= energy_d;
        end
    end

    // Actuators decode the registered state and drop at once while frozen
    assign fill_valve      = (state_q == ST_FILL)  && !hold;
    assign heater_on       = (state_q == ST_HEAT)  && !hold;
    assign wash_enable     = (state_q == ST_WASH)  && !hold;
    assign rinse_enable    = (state_q == ST_RINSE) && !hold;
    assign spin_enable     = (state_q == ST_SPIN)  && !hold;
    assign busy            = active || (state_q == ST_LOCK);
    assign complete        = (state_q == ST_DONE);
    assign fault           = (state_q == ST_FAULT);
    assign phase           = state_q;
    assign energy_consumed = energy_q;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed bench for wash_program_sequencer; a second instance with a
// 6-bit energy total shares the stimulus to exercise saturation.
module tb_wash_program_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, pause = 1'b0, enable_lock = 1'b0;
    logic water_ready = 1'b0, temp_ready = 1'b0, sense_ok = 1'b0;
    logic [1:0] cycle_mode = 2'b00, rinse_count = 2'b00;

    logic fill_valve, heater_on, wash_enable, rinse_enable, spin_enable;
    logic busy, complete, fault;
    logic [3:0]  phase;
    logic [11:0] energy_consumed;

    logic fill_valve_s, heater_on_s, wash_enable_s, rinse_enable_s, spin_enable_s;
    logic busy_s, complete_s, fault_s;
    logic [3:0] phase_s;
    logic [5:0] energy_s;

    int checks = 0;
    int failures = 0;

    wash_program_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .enable_lock(enable_lock), .water_ready(water_ready),
        .temp_ready(temp_ready), .sense_ok(sense_ok),
        .cycle_mode(cycle_mode), .rinse_count(rinse_count),
        .fill_valve(fill_valve), .heater_on(heater_on),
        .wash_enable(wash_enable), .rinse_enable(rinse_enable),
        .spin_enable(spin_enable), .busy(busy), .complete(complete),
        .fault(fault), .phase(phase), .energy_consumed(energy_consumed)
    );

    wash_program_sequencer #(.ENERGY_W(6)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .enable_lock(enable_lock), .water_ready(water_ready),
        .temp_ready(temp_ready), .sense_ok(sense_ok),
        .cycle_mode(cycle_mode), .rinse_count(rinse_count),
        .fill_valve(fill_valve_s), .heater_on(heater_on_s),
        .wash_enable(wash_enable_s), .rinse_enable(rinse_enable_s),
        .spin_enable(spin_enable_s), .busy(busy_s), .complete(complete_s),
        .fault(fault_s), .phase(phase_s), .energy_consumed(energy_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input string tag, input int p, input int bound);
        int n = 0;
        while (int'(phase) != p && n < bound) begin
            step();
            n++;
        end
        check(tag, int'(phase), p);
    endtask

    function automatic int outs();
        return int'({fill_valve, heater_on, wash_enable, rinse_enable,
                     spin_enable, busy, complete, fault});
    endfunction

    initial begin
        int wc, rc, sc, n;
        logic saw_wash;

        // Reset state
        step(); step();
        check("reset_phase", int'(phase), 0);
        check("reset_outs", outs(), 0);
        check("reset_energy", int'(energy_consumed), 0);

        // Quick mode, two rinses, everything ready immediately
        reset = 1'b0;
        enable_lock = 1'b1; water_ready = 1'b1; temp_ready = 1'b1; sense_ok = 1'b1;
        cycle_mode = 2'b01; rinse_count = 2'd2; start = 1'b1;
        step();
        check("q_lock_phase", int'(phase), 1);
        check("q_lock_busy", int'(busy), 1);
        cycle_mode = 2'b10;
        wc = 0; rc = 0; sc = 0; n = 0;
        while (!complete && n < 300) begin
            step();
            n++;
            if (wash_enable)  wc++;
            if (rinse_enable) rc++;
            if (spin_enable)  sc++;
        end
        check("q_complete", int'(complete), 1);
        check("q_wash_cycles", wc, 20);
        check("q_rinse_cycles", rc, 20);
        check("q_spin_cycles", sc, 15);
        check("q_energy", int'(energy_consumed), 110);
        check("q_busy_done", int'(busy), 0);
        step();
        check("q_done_hold", int'(complete), 1);
        start = 1'b0;
        step();
        check("q_idle_phase", int'(phase), 0);
        check("q_idle_complete", int'(complete), 0);

        // Fill timeout
        water_ready = 1'b0; cycle_mode = 2'b00; start = 1'b1;
        step(); step();
        check("to_fill_phase", int'(phase), 2);
        check("to_fill_valve", int'(fill_valve), 1);
        n = 1;
        while (int'(phase) == 2 && n < 300) begin
            step();
            if (int'(phase) == 2) n++;
        end
        check("to_fill_cycles", n, 200);
        check("to_fault", int'(fault), 1);
        start = 1'b0; step();
        start = 1'b1; step();
        check("to_fault_sticky", int'(phase), 8);
        check("to_fault_outs", outs(), 1);

        // Normal mode, rinse_count 0, pause mid-wash and door open mid-rinse
        reset = 1'b1; start = 1'b0; step();
        check("rst_from_fault", int'(phase), 0);
        reset = 1'b0;
        water_ready = 1'b1; rinse_count = 2'd0; start = 1'b1;
        wait_phase("p_reach_wash", 4, 10);
        check("p_energy_wash_entry", int'(energy_consumed), 5);
        wc = 0;
        while (int'(phase) == 4 && wc < 100) begin
            wc++;
            if (wc == 10) pause = 1'b1;
            if (wc == 15) pause = 1'b0;
            #1;
            if (wc == 12) begin
                check("p_wash_en_paused", int'(wash_enable), 0);
                check("p_energy_frozen", int'(energy_consumed), 23);
            end
            step();
        end
        check("p_wash_wall", wc, 45);
        check("p_rinse_phase", int'(phase), 5);
        check("p_energy_after_wash", int'(energy_consumed), 85);
        rc = 0;
        while (int'(phase) == 5 && rc < 100) begin
            rc++;
            if (rc == 5) enable_lock = 1'b0;
            if (rc == 8) enable_lock = 1'b1;
            #1;
            if (rc == 6) check("p_rinse_en_unlocked", int'(rinse_enable), 0);
            step();
        end
        check("p_rinse_wall", rc, 23);
        wait_phase("p_done", 7, 100);
        check("p_energy_total", int'(energy_consumed), 195);
        start = 1'b0; step();

        // Heavy program, three rinses; 6-bit instance must saturate
        cycle_mode = 2'b10; rinse_count = 2'd3; start = 1'b1;
        wait_phase("h_done", 7, 600);
        check("h_energy", int'(energy_consumed), 335);
        check("h_sat_energy", int'(energy_s), 63);
        check("h_sat_complete", int'(complete_s), 1);
        start = 1'b0; step();

        // Reset during spin
        cycle_mode = 2'b01; rinse_count = 2'd1; start = 1'b1;
        wait_phase("r_reach_spin", 6, 100);
        step(); step();
        check("r_spin_en", int'(spin_enable), 1);
        reset = 1'b1;
        step();
        check("r_phase", int'(phase), 0);
        check("r_outs", outs(), 0);
        check("r_energy", int'(energy_consumed), 0);
        reset = 1'b0; start = 1'b0;
        step();
        check("r_stays_idle", int'(phase), 0);

        // sense_ok low at temperature: straight to fault, never washing
        sense_ok = 1'b0; cycle_mode = 2'b00; start = 1'b1;
        saw_wash = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wash_enable) saw_wash = 1'b1;
        end
        check("s_fault_phase", int'(phase), 8);
        check("s_fault_flag", int'(fault), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            if (wash_enable) saw_wash = 1'b1;
        end
        check("s_no_wash", int'(saw_wash), 0);
        check("s_still_fault", int'(phase), 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wash_program_sequencer.md
WASH_PROGRAM_SEQUENCER -- requirements
Module: wash_program_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, phase-timer width in bits.
REQ-002 SHALL have parameter ENERGY_W, default 12, energy accumulator width in bits.
REQ-003 SHALL have parameter MAX_RINSE, default 3, maximum rinse repetitions.
REQ-004 SHALL have parameter TIMEOUT, default 200, fill/heat timeout in cycles.
REQ-005 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  program request level.
REQ-008 SHALL have port pause  in  1  freeze request level.
REQ-009 SHALL have port enable_lock  in  1  door-locked status.
REQ-010 SHALL have port water_ready  in  1  water level reached.
REQ-011 SHALL have port temp_ready  in  1  temperature reached.
REQ-012 SHALL have port sense_ok  in  1  detergent present and load balanced.
REQ-013 SHALL have port cycle_mode  in  2  00 normal, 01 quick, 10 heavy, 11 delicate.
REQ-014 SHALL have port rinse_count  in  2  requested rinse repetitions.
REQ-015 SHALL have outputs fill_valve, heater_on, wash_enable, rinse_enable, spin_enable  out  1 each  actuator enables.
REQ-016 SHALL have outputs busy, complete, fault  out  1 each  status flags.
REQ-017 SHALL have output phase  out  4  current state encoding.
REQ-018 SHALL have output energy_consumed  out  ENERGY_W  saturating energy total.

Function
REQ-019 SHALL implement states IDLE, LOCK, FILL, HEAT, WASH, RINSE, SPIN, DONE, FAULT.
REQ-020 IDLE with start=1 SHALL go to LOCK next cycle and latch cycle_mode and rinse_count (0 becomes 1, values above MAX_RINSE clamp to MAX_RINSE), and SHALL clear energy_consumed.
REQ-021 LOCK SHALL wait for enable_lock=1, then go to FILL.
REQ-022 FILL SHALL assert fill_valve until water_ready=1, then go to HEAT.
REQ-023 HEAT SHALL assert heater_on until temp_ready=1, then go to WASH if sense_ok=1, else to FAULT.
REQ-024 FILL or HEAT lasting TIMEOUT cycles without its ready signal SHALL go to FAULT.
REQ-025 WASH, each RINSE pass, and SPIN SHALL each last exactly the mode-table duration in cycles, with the matching enable high throughout.
REQ-026 Mode-table durations (wash/rinse/spin) SHALL be: normal 40/20/30; quick 20/10/15; heavy 60/30/40; delicate 30/20/10.
REQ-027 RINSE SHALL repeat the latched count times back-to-back, then go to SPIN.
REQ-028 SPIN expiry SHALL go to DONE.
REQ-029 DONE SHALL hold complete=1 until start=0, then return to IDLE.
REQ-030 pause=1 or enable_lock=0 in FILL through SPIN SHALL freeze the timer, the timeout counter and the energy total, and SHALL deassert all actuators; operation SHALL resume on release with no loss of count.
REQ-031 Energy per unpaused cycle SHALL add: fill_valve 1, heater_on 4, wash 2, rinse 1, spin 3.
REQ-032 The energy total SHALL saturate at 2^ENERGY_W-1.
REQ-033 busy SHALL be 1 in LOCK through SPIN.
REQ-034 fault SHALL be 1 in FAULT; FAULT SHALL exit only on reset.
REQ-035 start changes outside IDLE/DONE SHALL be ignored, and cycle_mode changes after latching SHALL have no effect.

Reset
REQ-036 reset SHALL take priority over all inputs and force IDLE on the next edge.
REQ-037 After reset, all outputs, the timers and the latched mode/count SHALL be 0, including when reset is applied mid-program.

Structure
REQ-038 A shared package SHALL hold the state enum, the mode encodings, the duration table and the energy rates.
REQ-039 A sub-module phase_timer SHALL provide down-counter load, hold and expire behaviour.

Verification
REQ-040 Bench: quick mode, rinse_count=2, all ready signals immediate -> WASH 20, RINSE 2x10, SPIN 15 cycles, then complete=1.
REQ-041 Bench: water_ready never asserted -> fault=1 exactly TIMEOUT=200 cycles after FILL entry.
REQ-042 Bench: pause for 5 cycles mid-WASH in normal mode -> WASH spans 45 cycles of wall time and energy rises by exactly 80 for the wash phase.
REQ-043 Bench: ENERGY_W=6 with a heavy program -> energy_consumed holds at 63.
REQ-044 Bench: reset mid-SPIN -> IDLE with all outputs 0 on the next cycle.
REQ-045 Bench: sense_ok=0 when temp_ready=1 -> FAULT, with no wash_enable pulse.
